// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: start/operand/result bundle between control unit and multdiv_unit.
// MULTDIV_UNSIGNED_EN adds the is_unsigned request qualifier.
interface multdiv_unit_if #(parameter int WIDTH = 32);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divby0flag;
`ifdef MULTDIV_UNSIGNED_EN
    logic             is_unsigned;
    modport master (output start_mult, start_div, a, b, is_unsigned,
                    input hi, lo, busy, done, divby0flag);
    modport slave (input start_mult, start_div, a, b, is_unsigned,
                   output hi, lo, busy, done, divby0flag);
`else
    modport master (output start_mult, start_div, a, b,
                    input hi, lo, busy, done, divby0flag);
    modport slave (input start_mult, start_div, a, b,
                   output hi, lo, busy, done, divby0flag);
`endif
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed Booth multiply / restoring divide, fixed 34-cycle latency.
// Define MULTDIV_UNSIGNED_EN to add unsigned (multu/divu) operation via bus.is_unsigned.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input logic          clk,
    input logic          reset,
    multdiv_unit_if.slave bus
);
    localparam int CW = $clog2(ITER);
    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   ra, mx, addend, sum, r2;
    logic [WIDTH-1:0] rq, m, am, bm;
    logic qm1, op_div, uns, uns_r, sa, sb, neg_q, neg_r, bz;
    logic accept, fin, divz, last, ge;
`ifdef MULTDIV_UNSIGNED_EN
    assign uns = bus.is_unsigned;
`else
    assign uns = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start_mult ? MULT : bus.start_div ? DIV : IDLE;
            MULT:    state_n = last ? FIX : MULT;
            DIV:     state_n = bz ? IDLE : last ? FIX : DIV;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        accept = (state == IDLE) && (bus.start_mult || bus.start_div);
        divz   = (state == DIV) && bz;
        fin    = (state == DONE) || divz;
        last   = cnt == CW'(ITER - 1);
        sa     = ~uns & bus.a[WIDTH-1];
        sb     = ~uns & bus.b[WIDTH-1];
        am     = sa ? -bus.a : bus.a;
        bm     = sb ? -bus.b : bus.b;
        // unsigned multiply degenerates to plain shift-add on the multiplier lsb
        mx     = {~uns_r & m[WIDTH-1], m};
        addend = uns_r ? (rq[0] ? mx : '0)
                       : (rq[0] & ~qm1) ? -mx : (~rq[0] & qm1) ? mx : '0;
        sum    = ra + addend;
        r2     = {ra[WIDTH-1:0], rq[WIDTH-1]};
        ge     = r2 >= {1'b0, m};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            ra             <= '0;
            rq             <= '0;
            m              <= '0;
            qm1            <= 1'b0;
            op_div         <= 1'b0;
            uns_r          <= 1'b0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            bz             <= 1'b0;
            bus.hi         <= '0;
            bus.lo         <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.divby0flag <= 1'b0;
        end else begin
            bus.done <= fin;
            if (accept) begin
                op_div         <= ~bus.start_mult;
                uns_r          <= uns;
                neg_q          <= sa ^ sb;
                neg_r          <= sa;
                bz             <= ~bus.start_mult && (bus.b == '0);
                ra             <= '0;
                qm1            <= 1'b0;
                rq             <= bus.start_mult ? bus.b : am;
                m              <= bus.start_mult ? bus.a : bm;
                cnt            <= '0;
                bus.busy       <= 1'b1;
                bus.divby0flag <= 1'b0;
            end else if (state == MULT) begin
                ra  <= {~uns_r & sum[WIDTH], sum[WIDTH:1]};
                rq  <= {sum[0], rq[WIDTH-1:1]};
                qm1 <= rq[0];
                cnt <= cnt + 1'b1;
            end else if (state == DIV && !bz) begin
                ra  <= ge ? r2 - {1'b0, m} : r2;
                rq  <= {rq[WIDTH-2:0], ge};
                cnt <= cnt + 1'b1;
            end else if (state == FIX && op_div) begin
                rq <= neg_q ? -rq : rq;
                ra <= {1'b0, neg_r ? -ra[WIDTH-1:0] : ra[WIDTH-1:0]};
            end
            if (fin) begin
                bus.busy <= 1'b0;
                if (divz) bus.divby0flag <= 1'b1;
                else begin
                    bus.hi <= ra[WIDTH-1:0];
                    bus.lo <= rq;
                end
            end
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed vectors for multdiv_unit with hand-computed HI/LO results.
// Unsigned vectors run only when MULTDIV_UNSIGNED_EN is defined.
module tb_multdiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int n;
    int dones;
    multdiv_unit_if #(.WIDTH(32)) bus();
    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic go(input logic sm, input logic sd, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start_mult = sm;
        bus.start_div  = sd;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
    endtask
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.done && cyc < 100);
        if (!bus.done) check("timeout", {63'd0, bus.done}, 64'd1);
    endtask
    task automatic op(input string tag, input logic sm, input logic sd,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el, input int lat);
        int c;
        go(sm, sd, x, y);
        wait_done(c);
        check({tag, "_lat"}, 64'(c), 64'(lat));
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
        check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask
    initial begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef MULTDIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dz", {63'd0, bus.divby0flag}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        op("m7x-3", 1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34);
        // ignored start_div mid-operation, hi/lo must not move
        go(1, 0, 32'h80000000, 32'h80000000);
        check("mmin_busy", {63'd0, bus.busy}, 64'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start_div = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'd0;
        @(posedge clk);
        #1;
        bus.start_div = 1'b0;
        check("mmin_hold_hi", {32'd0, bus.hi}, 64'hFFFFFFFF);
        check("mmin_hold_lo", {32'd0, bus.lo}, 64'hFFFFFFEB);
        wait_done(n);
        check("mmin_lat", 64'(n + 6), 64'd34);
        check("mmin_hi", {32'd0, bus.hi}, 64'h40000000);
        check("mmin_lo", {32'd0, bus.lo}, 64'd0);
        check("mmin_dz", {63'd0, bus.divby0flag}, 64'd0);
        @(posedge clk);
        #1;
        check("done_pulse", {63'd0, bus.done}, 64'd0);
        op("d-7/2", 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
        op("dovf", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 34);
        op("d100/7", 0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        op("d-100/-7", 0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 34);
        op("m3x5", 1, 0, 32'd3, 32'd5, 32'd0, 32'd15, 34);
        op("d9/0", 0, 1, 32'd9, 32'd0, 32'd0, 32'd15, 1);
        check("dz_flag", {63'd0, bus.divby0flag}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("dz_hold", {63'd0, bus.divby0flag}, 64'd1);
        go(1, 0, 32'd2, 32'd3);
        check("dz_clear", {63'd0, bus.divby0flag}, 64'd0);
        wait_done(n);
        check("m2x3_lo", {32'd0, bus.lo}, 64'd6);
        // reset in the middle of a multiply
        go(1, 0, 32'd4, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hi", {32'd0, bus.hi}, 64'd0);
        check("abort_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_nodone", 64'(dones), 64'd0);
        op("both", 1, 1, 32'd6, 32'd7, 32'd0, 32'd42, 34);
`ifdef MULTDIV_UNSIGNED_EN
        bus.is_unsigned = 1'b1;
        op("multu", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
        op("divu", 0, 1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'h7FFFFFFF, 34);
        bus.is_unsigned = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
